// File: rtl/clk_mux_pkg.sv
// Shared types and defaults for the safe clock multiplexer and its sequencing controller.
package clk_mux_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DROP,
    S_RAISE
  } state_t;

  localparam int CLK_MUX_DEF_GAP    = 8;
  localparam int CLK_MUX_DEF_CLK    = 0;
  localparam int CLK_MUX_MAX_CLOCKS = 32;

  // Callers cast the result down to their own clock count.
  function automatic logic [CLK_MUX_MAX_CLOCKS-1:0] sel_onehot(input int unsigned idx);
    return CLK_MUX_MAX_CLOCKS'(1) << idx;
  endfunction

endpackage

// File: rtl/clk_mux_ctrl.sv
// Break-before-make sequencer for the safe clock mux: drop all enables for a guard gap,
// raise the new one-hot enable, wait a settle gap, then report completion.
module clk_mux_ctrl
  import clk_mux_pkg::*;
#(
  parameter int P_NO_CLOCKS  = 4,
  parameter int P_SEL_W      = 2,
  parameter int P_GAP_CYCLES = CLK_MUX_DEF_GAP,
  parameter int P_DEF_CLK    = CLK_MUX_DEF_CLK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_req,
  input  logic [P_SEL_W-1:0]     sw_sel,
  output logic                   sw_busy,
  output logic                   sw_done,
  output logic                   sw_err,
  output logic [P_SEL_W-1:0]     cur_sel,
  output logic [P_NO_CLOCKS-1:0] clk_en_vec
);

  localparam int CNT_W = $clog2(P_GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(P_GAP_CYCLES - 1);
  localparam logic [P_SEL_W-1:0] DEF_SEL = P_SEL_W'(P_DEF_CLK);

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [P_SEL_W-1:0]       target, target_nxt;
  logic [P_SEL_W-1:0]       cur_sel_nxt;
  logic [P_NO_CLOCKS-1:0]   en_nxt;
  logic                     busy_nxt;
  logic                     done_nxt;
  logic                     err_nxt;
  logic                     sel_valid;
  logic [P_NO_CLOCKS-1:0]   oh_cur;
  logic [P_NO_CLOCKS-1:0]   oh_tgt;

  assign sel_valid = (32'(sw_sel) < 32'(P_NO_CLOCKS));
  assign oh_cur    = P_NO_CLOCKS'(sel_onehot(32'(cur_sel)));
  assign oh_tgt    = P_NO_CLOCKS'(sel_onehot(32'(target)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_DROP;
      cnt        <= CNT_LOAD;
      target     <= DEF_SEL;
      cur_sel    <= DEF_SEL;
      clk_en_vec <= '0;
      sw_busy    <= 1'b1;
      sw_done    <= 1'b0;
      sw_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      target     <= target_nxt;
      cur_sel    <= cur_sel_nxt;
      clk_en_vec <= en_nxt;
      sw_busy    <= busy_nxt;
      sw_done    <= done_nxt;
      sw_err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    target_nxt  = target;
    cur_sel_nxt = cur_sel;
    en_nxt      = clk_en_vec;
    busy_nxt    = sw_busy;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    unique case (state)
      S_IDLE: begin
        en_nxt   = oh_cur;
        busy_nxt = 1'b0;
        if (sw_req) begin
          if (!sel_valid) begin
            err_nxt = 1'b1;
          end else if (sw_sel == cur_sel) begin
            done_nxt = 1'b1;
          end else begin
            target_nxt = sw_sel;
            state_nxt  = S_DROP;
            cnt_nxt    = CNT_LOAD;
            en_nxt     = '0;
            busy_nxt   = 1'b1;
          end
        end
      end

      S_DROP: begin
        en_nxt   = '0;
        busy_nxt = 1'b1;
        err_nxt  = sw_req;
        if (cnt == '0) begin
          state_nxt   = S_RAISE;
          cnt_nxt     = CNT_LOAD;
          cur_sel_nxt = target;
          en_nxt      = oh_tgt;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      S_RAISE: begin
        en_nxt   = oh_tgt;
        busy_nxt = 1'b1;
        if (cnt == '0) begin
          // Completion owns this cycle's status pulse; a colliding request is dropped quietly
          // so that done and err never assert together.
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
          err_nxt = sw_req;
        end
      end

      default: begin
        state_nxt = S_DROP;
        cnt_nxt   = CNT_LOAD;
        en_nxt    = '0;
        busy_nxt  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_clk_mux_ctrl.sv
// Randomized bench for clk_mux_ctrl against a timeline model of the switch sequence.
module tb_clk_mux_ctrl;

  localparam int NC  = 3;
  localparam int SW  = 2;
  localparam int G   = 8;
  localparam int DEF = 0;
  localparam logic [7:0] RST_VEC = {3'b000, 2'(DEF), 1'b1, 1'b0, 1'b0};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_req = 1'b0;
  logic [SW-1:0] sw_sel = '0;
  logic          sw_busy, sw_done, sw_err;
  logic [SW-1:0] cur_sel;
  logic [NC-1:0] clk_en_vec;

  clk_mux_ctrl #(
    .P_NO_CLOCKS (NC),
    .P_SEL_W     (SW),
    .P_GAP_CYCLES(G),
    .P_DEF_CLK   (DEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_req    (sw_req),
    .sw_sel    (sw_sel),
    .sw_busy   (sw_busy),
    .sw_done   (sw_done),
    .sw_err    (sw_err),
    .cur_sel   (cur_sel),
    .clk_en_vec(clk_en_vec)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Timeline model: the last accepted switch started at m_start; drop window is
  // m_start+1..m_start+G, raise window up to m_start+2G, done at m_start+2G+1.
  int t;
  int m_start, m_prev, m_new, m_same_done, m_err;

  logic [7:0] obs;
  assign obs = {clk_en_vec, cur_sel, sw_busy, sw_done, sw_err};

  function automatic int cur_at(input int tt);
    return (tt > m_start + G) ? m_new : m_prev;
  endfunction

  function automatic bit busy_at(input int tt);
    return (tt >= m_start + 1) && (tt <= m_start + 2 * G);
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [2:0] e_en;
    logic       e_done;
    if (t >= m_start + 1 && t <= m_start + G) e_en = 3'b000;
    else                                      e_en = 3'(1 << cur_at(t));
    e_done = (t == m_start + 2 * G + 1) || (t == m_same_done);
    return {e_en, 2'(cur_at(t)), busy_at(t), e_done, (t == m_err)};
  endfunction

  task automatic model_req(input logic req, input int sel);
    int c;
    if (!req) return;
    if (t == m_start + 2 * G) return;
    c = cur_at(t);
    if (busy_at(t) || sel >= NC) m_err = t + 1;
    else if (sel == c)           m_same_done = t + 1;
    else begin
      m_prev  = c;
      m_new   = sel;
      m_start = t;
    end
  endtask

  task automatic tick(input logic req, input int sel);
    sw_req = req;
    sw_sel = SW'(sel);
    model_req(req, sel);
    @(posedge clk);
    #1;
    sw_req = 1'b0;
    @(negedge clk);
    t++;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    rst_n       = 1'b1;
    t           = 1;
    m_start     = 0;
    m_prev      = DEF;
    m_new       = DEF;
    m_same_done = -100;
    m_err       = -100;
  endtask

  task automatic test_reset();
    hold_reset();
    checks++;
    if (obs !== RST_VEC) begin
      failures++;
      $display("FAIL reset_values got=%b want=%b", obs, RST_VEC);
    end
    release_reset();
    for (int i = 0; i < 2 * G + 4; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL init_seq t=%0d got=%b want=%b", t, obs, exp_vec());
      end
      tick(1'b0, 0);
    end
  endtask

  task automatic test_switch();
    for (int i = 0; i < 2 * G + 4; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL switch_to_2 t=%0d got=%b want=%b", t, obs, exp_vec());
      end
      tick(i == 0, 2);
    end
  endtask

  task automatic test_same_sel();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL same_sel t=%0d got=%b want=%b", t, obs, exp_vec());
      end
      tick(i == 0, 2);
    end
  endtask

  task automatic test_invalid();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL invalid_sel t=%0d got=%b want=%b", t, obs, exp_vec());
      end
      tick(i == 0, 3);
    end
  endtask

  task automatic test_busy_reject();
    for (int i = 0; i < 2 * G + 4; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL busy_reject t=%0d got=%b want=%b", t, obs, exp_vec());
      end
      if (i == 0)      tick(1'b1, 1);
      else if (i == 4) tick(1'b1, 3);
      else             tick(1'b0, 0);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL pre_reset t=%0d got=%b want=%b", t, obs, exp_vec());
      end
      tick(i == 0, (cur_at(t) + 1) % NC);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      failures++;
      $display("FAIL async_reset_immediate got=%b want=%b", obs, RST_VEC);
    end
    hold_reset();
    checks++;
    if (obs !== RST_VEC) begin
      failures++;
      $display("FAIL async_reset_held got=%b want=%b", obs, RST_VEC);
    end
    release_reset();
    for (int i = 0; i < 2 * G + 3; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL reinit_seq t=%0d got=%b want=%b", t, obs, exp_vec());
      end
      tick(1'b0, 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random t=%0d got=%b want=%b", t, obs, exp_vec());
      end
      tick($urandom_range(0, 4) == 0, int'($urandom_range(0, 3)));
    end
  endtask

  // Continuous safety monitor: never multi-hot, and at least G zero cycles between distinct enables.
  logic [NC-1:0] last_oh;
  int            zero_run;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_oh  = '0;
      zero_run = 0;
    end else begin
      checks++;
      if ($countones(clk_en_vec) > 1) begin
        failures++;
        $display("FAIL onehot_safety got=%b want=at most one bit", clk_en_vec);
      end
      if (clk_en_vec == '0) begin
        zero_run++;
      end else begin
        if (last_oh != '0 && clk_en_vec != last_oh) begin
          checks++;
          if (zero_run < G) begin
            failures++;
            $display("FAIL break_before_make gap=%0d want>=%0d", zero_run, G);
          end
        end
        last_oh  = clk_en_vec;
        zero_run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_switch();
    test_same_sel();
    test_invalid();
    test_busy_reject();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
